alu_reg_file: RTL and testbench

Four-entry 8-bit general-purpose register file sitting directly upstream of the ALU: its two read ports drive the ALU `A` and `B` operands, and its write port takes either the ALU result (`OutALU`) or external data on `I`. Each write cycle applies one of four register micro-operations (clear, load, decrement, increment) to every register selected in a one-hot-or-multi mask. An optional 4-bit flag register captures the ALU `ZCNO` outputs.

---
 rtl/alu_reg_file.sv | 74 +++++++
 tb/tb_alu_reg_file.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_reg_file.sv
// rtl/alu_reg_file.sv - four-entry register file feeding ALU operands; optional flag register via REGFILE_FLAGS_EN
module alu_reg_file #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] I,
    input  logic [3:0]       RegSel,
    input  logic [1:0]       FunSel,
    input  logic [1:0]       OutASel,
    input  logic [1:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
`ifdef REGFILE_FLAGS_EN
    ,
    input  logic [3:0]       ZCNOIn,
    input  logic             FlagWE,
    output logic [3:0]       Flags
`endif
);

    typedef enum logic [1:0] {
        FUN_CLR = 2'b00,
        FUN_LD  = 2'b01,
        FUN_DEC = 2'b10,
        FUN_INC = 2'b11
    } fun_e;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    // Each selected register applies the op to its own value; wrap is natural modulo arithmetic.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            regs_d[k] = regs_q[k];
            if (RegSel[k]) begin
                case (fun_e'(FunSel))
                    FUN_CLR: regs_d[k] = '0;
                    FUN_LD:  regs_d[k] = I;
                    FUN_DEC: regs_d[k] = regs_q[k] - WIDTH'(1);
                    FUN_INC: regs_d[k] = regs_q[k] + WIDTH'(1);
                    default: regs_d[k] = regs_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
        end
    end

    assign OutA = regs_q[OutASel];
    assign OutB = regs_q[OutBSel];

`ifdef REGFILE_FLAGS_EN
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    assign flags_d = FlagWE ? ZCNOIn : flags_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign Flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_reg_file.sv
// tb/tb_alu_reg_file.sv - directed vector bench for alu_reg_file (flag checks under REGFILE_FLAGS_EN)
module tb_alu_reg_file;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_ext;
    logic       use_alu;
    logic [3:0] reg_sel;
    logic [1:0] fun_sel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] alu_sum;
    logic [7:0] i_w;

    int n_cmp;
    int n_bad;

    assign alu_sum = out_a + out_b;
    assign i_w     = use_alu ? alu_sum : i_ext;

`ifdef REGFILE_FLAGS_EN
    logic [3:0] zcno_ovr;
    logic       zcno_use_alu;
    logic [3:0] zcno_w;
    logic       flag_we;
    logic [3:0] flags;
    logic [8:0] sum9;

    assign sum9   = {1'b0, out_a} + {1'b0, out_b};
    assign zcno_w = zcno_use_alu
                  ? {(sum9[7:0] == 8'h00), sum9[8], sum9[7],
                     ((out_a[7] == out_b[7]) && (sum9[7] != out_a[7]))}
                  : zcno_ovr;
`endif

    alu_reg_file #(.WIDTH(8), .NREG(4)) dut (
        .CLK     (clk),
        .RSTn    (rst_n),
        .I       (i_w),
        .RegSel  (reg_sel),
        .FunSel  (fun_sel),
        .OutASel (a_sel),
        .OutBSel (b_sel),
        .OutA    (out_a),
        .OutB    (out_b)
`ifdef REGFILE_FLAGS_EN
        ,
        .ZCNOIn  (zcno_w),
        .FlagWE  (flag_we),
        .Flags   (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rs;
        logic [1:0] fs;
        logic [7:0] din;
        logic [1:0] as;
        logic [1:0] bs;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rs, input logic [1:0] fs, input logic [7:0] din,
                         input logic [1:0] as, input logic [1:0] bs);
        reg_sel = rs;
        fun_sel = fs;
        i_ext   = din;
        a_sel   = as;
        b_sel   = bs;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        use_alu = 1'b0;
        drive(4'b0000, 2'b01, 8'h00, 2'd0, 2'd1);
`ifdef REGFILE_FLAGS_EN
        flag_we      = 1'b0;
        zcno_use_alu = 1'b0;
        zcno_ovr     = 4'b1010;
`endif

        vecs[0]  = '{4'b0001, 2'b01, 8'h05, 2'd0, 2'd1, 8'h05, 8'h00};
        vecs[1]  = '{4'b0010, 2'b01, 8'h02, 2'd0, 2'd1, 8'h05, 8'h02};
        vecs[2]  = '{4'b0000, 2'b01, 8'h77, 2'd2, 2'd3, 8'h00, 8'h00};
        vecs[3]  = '{4'b0100, 2'b01, 8'hFF, 2'd2, 2'd3, 8'hFF, 8'h00};
        vecs[4]  = '{4'b0100, 2'b11, 8'h00, 2'd2, 2'd3, 8'h00, 8'h00};
        vecs[5]  = '{4'b0100, 2'b10, 8'h00, 2'd2, 2'd3, 8'hFF, 8'h00};
        vecs[6]  = '{4'b1000, 2'b10, 8'h00, 2'd2, 2'd3, 8'hFF, 8'hFF};
        vecs[7]  = '{4'b0001, 2'b01, 8'h00, 2'd0, 2'd1, 8'h00, 8'h02};
        vecs[8]  = '{4'b0010, 2'b01, 8'h7F, 2'd0, 2'd1, 8'h00, 8'h7F};
        vecs[9]  = '{4'b1000, 2'b01, 8'h10, 2'd2, 2'd3, 8'hFF, 8'h10};
        vecs[10] = '{4'b1111, 2'b11, 8'h00, 2'd0, 2'd1, 8'h01, 8'h80};
        vecs[11] = '{4'b0000, 2'b00, 8'h00, 2'd2, 2'd3, 8'h00, 8'h11};
        vecs[12] = '{4'b1111, 2'b00, 8'h00, 2'd0, 2'd3, 8'h00, 8'h00};
        vecs[13] = '{4'b0000, 2'b01, 8'h55, 2'd1, 2'd2, 8'h00, 8'h00};
        vecs[14] = '{4'b0011, 2'b01, 8'h3C, 2'd0, 2'd0, 8'h3C, 8'h3C};

        // Reset held across edges: everything reads zero.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", out_a, 8'h00);
        chk("reset_b", out_b, 8'h00);
`ifdef REGFILE_FLAGS_EN
        chk("reset_flags", {4'h0, flags}, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].rs, vecs[v].fs, vecs[v].din, vecs[v].as, vecs[v].bs);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_a", v), out_a, vecs[v].exp_a);
            chk($sformatf("vec%0d_b", v), out_b, vecs[v].exp_b);
            @(negedge clk);
        end

        // Asynchronous reset between edges after loading 0xAA everywhere.
        drive(4'b1111, 2'b01, 8'hAA, 2'd0, 2'd3);
        @(posedge clk);
        #1;
        chk("load_aa_a", out_a, 8'hAA);
        chk("load_aa_b", out_b, 8'hAA);
        @(negedge clk);
        drive(4'b0000, 2'b01, 8'h00, 2'd1, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", out_a, 8'h00);
        chk("async_rst_b", out_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a pending increment discards the op.
        drive(4'b1111, 2'b01, 8'h40, 2'd0, 2'd2);
        @(posedge clk);
        @(negedge clk);
        drive(4'b1111, 2'b11, 8'h00, 2'd0, 2'd2);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pending_a", out_a, 8'h00);
        chk("rst_pending_b", out_b, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU feedback: R1 = R1 + R2 through I, old value visible until the edge.
        drive(4'b0001, 2'b01, 8'h7F, 2'd0, 2'd1);
        @(posedge clk);
        @(negedge clk);
        drive(4'b0010, 2'b01, 8'h01, 2'd0, 2'd1);
        @(posedge clk);
        @(negedge clk);
        drive(4'b0001, 2'b01, 8'h00, 2'd0, 2'd1);
        use_alu = 1'b1;
`ifdef REGFILE_FLAGS_EN
        zcno_use_alu = 1'b1;
        flag_we      = 1'b1;
`endif
        #1;
        chk("alu_pre_edge_a", out_a, 8'h7F);
        chk("alu_sum_pre", alu_sum, 8'h80);
        @(posedge clk);
        #1;
        chk("alu_fb_r1", out_a, 8'h80);
        chk("alu_fb_r2", out_b, 8'h01);
`ifdef REGFILE_FLAGS_EN
        chk("alu_flags", {4'h0, flags}, 8'h03);
`endif
        @(negedge clk);
        use_alu = 1'b0;
        drive(4'b0000, 2'b01, 8'h00, 2'd0, 2'd1);

`ifdef REGFILE_FLAGS_EN
        // Flag hold while the flag input toggles.
        flag_we      = 1'b0;
        zcno_use_alu = 1'b0;
        for (int c = 0; c < 3; c++) begin
            zcno_ovr = (c % 2 == 0) ? 4'b1100 : 4'b0101;
            @(posedge clk);
            #1;
            chk($sformatf("flag_hold%0d", c), {4'h0, flags}, 8'h03);
            @(negedge clk);
        end
        flag_we  = 1'b1;
        zcno_ovr = 4'b1000;
        @(posedge clk);
        #1;
        chk("flag_write", {4'h0, flags}, 8'h08);
        @(negedge clk);
        flag_we = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
